// File: rtl/ser4_frame_arb.sv
// ser4_frame_arb: round-robin master for two requesters sharing one scl/sda link.
// A grant sends one frame: start condition, 4 data bits MSB first, stop condition.
// Every protocol phase lasts HALF clocks; the bus must sit idle HALF clocks
// before the next grant. All outputs are registered.
module ser4_frame_arb #(
  parameter int HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [3:0] code_a,
  input  logic       req_b,
  input  logic [3:0] code_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic       done,
  output logic       scl,
  output logic       sda
);

  // The counter must reach HALF while idle (bus-free time), not only HALF-1.
  localparam int CW = $clog2(HALF + 1);
  localparam logic [CW-1:0] PH_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] PH_FULL = CW'(HALF);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    BIT_LO  = 3'd2,
    BIT_HI  = 3'd3,
    STOP_LO = 3'd4,
    STOP_HI = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      shift_q, shift_d;
  logic [1:0]      bit_q, bit_d;
  logic            last_b_q, last_b_d;   // 1: last grant went to B
  logic            phase_end;
  logic            accept;
  logic            win_a;
  logic            scl_d, sda_d, gnt_a_d, gnt_b_d, busy_d, done_d;

  // State register plus the datapath that travels with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      last_b_q <= last_b_d;
    end
  end

  // Next-state logic: idle bus-free counting, arbitration, phase sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    last_b_d  = last_b_q;
    accept    = 1'b0;
    win_a     = 1'b0;
    phase_end = (cnt_q == PH_LAST);
    case (state_q)
      IDLE: begin
        // Saturate at HALF so a long idle keeps the bus marked free.
        if (cnt_q != PH_FULL) cnt_d = cnt_q + ONE;
        if ((cnt_q == PH_FULL) && (req_a || req_b)) begin
          accept   = 1'b1;
          // On a tie the requester that did not win last time goes next.
          win_a    = req_a && (!req_b || last_b_q);
          state_d  = START;
          cnt_d    = '0;
          shift_d  = win_a ? code_a : code_b;
          last_b_d = !win_a;
        end
      end
      default: begin
        cnt_d = phase_end ? '0 : cnt_q + ONE;
        if (phase_end) begin
          case (state_q)
            START: begin
              state_d = BIT_LO;
              bit_d   = 2'd3;
            end
            BIT_LO:  state_d = BIT_HI;
            BIT_HI: begin
              shift_d = {shift_q[2:0], 1'b0};
              if (bit_q == 2'd0) begin
                state_d = STOP_LO;
              end else begin
                bit_d   = bit_q - 2'd1;
                state_d = BIT_LO;
              end
            end
            STOP_LO: state_d = STOP_HI;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the next state.
  always_comb begin
    scl_d   = 1'b1;
    sda_d   = 1'b1;
    busy_d  = (state_d != IDLE);
    gnt_a_d = accept && win_a;
    gnt_b_d = accept && !win_a;
    done_d  = (state_q == STOP_HI) && phase_end;
    case (state_d)
      START: begin
        scl_d = 1'b1;
        sda_d = 1'b0;
      end
      BIT_LO: begin
        // Data only moves while scl is low; it is stable across BIT_LO.
        scl_d = 1'b0;
        sda_d = shift_d[3];
      end
      BIT_HI: begin
        scl_d = 1'b1;
        sda_d = sda;
      end
      STOP_LO: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
      STOP_HI: begin
        scl_d = 1'b1;
        sda_d = 1'b0;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  // Output registers; reset releases the bus, which can form a stop condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl   <= 1'b1;
      sda   <= 1'b1;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      scl   <= scl_d;
      sda   <= sda_d;
      gnt_a <= gnt_a_d;
      gnt_b <= gnt_b_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_ser4_frame_arb.sv
// Bench for ser4_frame_arb: two instances (HALF=4 and HALF=1), each with a
// frame-level reference model feeding a scoreboard queue and a bus monitor
// that decodes scl/sda and checks grants, timing and line protocol.
module tb_ser4_frame_arb;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    int who;    // 1 = A, 2 = B
    int code;
    int gcyc;   // cycle whose outputs show gnt
    int dcyc;   // cycle whose outputs show done
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int H = (gi == 0) ? 4 : 1;

    logic       rst_n, req_a, req_b, gnt_a, gnt_b, busy, done, scl, sda;
    logic [3:0] code_a, code_b;

    exp_t q[$];
    int   free_at;   // earliest posedge at which a request can be accepted
    int   last;      // last winner, 1 = A, 2 = B
    int   gp;        // decision posedge of the most recent grant
    int   last_d;    // done cycle of the most recent grant
    bit   fin;

    bit         pend;
    exp_t       pe;
    logic [3:0] rx;
    int         nb;
    logic       pscl, psda;

    ser4_frame_arb #(.HALF(H)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_a  (req_a),
      .code_a (code_a),
      .req_b  (req_b),
      .code_b (code_b),
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b),
      .busy   (busy),
      .done   (done),
      .scl    (scl),
      .sda    (sda)
    );

    task automatic c(input string n, input int a, input int e);
      chk($sformatf("H%0d_%s", H, n), a, e);
    endtask

    // Drive one cycle of inputs and advance the frame-level model.
    task automatic step(input bit ra, input logic [3:0] ca, input bit rb,
                        input logic [3:0] cb, input bit rs, output int win);
      int p;
      @(negedge clk);
      req_a  = ra;
      code_a = ca;
      req_b  = rb;
      code_b = cb;
      rst_n  = rs;
      p      = cyc + 1;
      win    = 0;
      if (!rs) begin
        free_at = p + H + 1;
        last    = 2;
      end else if (p >= free_at && (ra || rb)) begin
        win = (ra && (!rb || last == 2)) ? 1 : 2;
        q.push_back('{who: win, code: int'(win == 1 ? ca : cb),
                      gcyc: p, dcyc: p + 11 * H});
        gp      = p;
        last_d  = p + 11 * H;
        free_at = p + 12 * H + 1;
        last    = win;
      end
    endtask

    task automatic idle(input int n);
      int w;
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, w);
    endtask

    task automatic drain();
      int w;
      while (cyc <= last_d + H + 2) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, w);
    endtask

    // Hold one requester until the model grants it.
    task automatic req_frame(input int who, input logic [3:0] code);
      int w;
      bit got;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        step(who == 1, code, who == 2, code, 1'b1, w);
        got = (w == who);
      end
    endtask

    // Stimulus
    initial begin
      int w;
      bit ra, rb;
      logic [3:0] ca, cb;
      rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; code_a = '0; code_b = '0;
      free_at = 0; last = 2; gp = 0; last_d = 0; fin = 1'b0;

      // reset then quiet bus
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, w);
      idle(20);

      // single A frame
      req_frame(1, 4'b1010);
      drain();

      // tie from reset: A,B,A,B
      for (int i = 0; i < 2; i++) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, w);
      for (int i = 0, ng = 0; i < 400 && ng < 4; i++) begin
        step(1'b1, 4'b0001, 1'b1, 4'b0110, 1'b1, w);
        if (w != 0) ng++;
      end
      drain();

      // randomized requests, drops and code churn
      ra = 1'b0; rb = 1'b0;
      for (int t = 0; t < 500; t++) begin
        if (!ra) ra = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 24) == 0) ra = 1'b0;
        if (!rb) rb = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 24) == 0) rb = 1'b0;
        ca = 4'($urandom);
        cb = 4'($urandom);
        step(ra, ca, rb, cb, 1'b1, w);
        if (w == 1) ra = ($urandom_range(0, 1) == 1);
        if (w == 2) rb = ($urandom_range(0, 1) == 1);
      end
      drain();

      // reset while in BIT_HI of the MSB with sda low, then re-request A
      req_frame(2, 4'b0000);
      while (cyc + 1 < gp + 2 * H + 1) idle(1);
      step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, w);
      req_frame(1, 4'b0101);
      drain();

      // B pulses for one cycle during an A frame and must be ignored
      req_frame(1, 4'($urandom));
      idle(3 * H);
      step(1'b0, 4'h0, 1'b1, 4'b1111, 1'b1, w);
      drain();
      idle(2 * H);
      fin = 1'b1;
    end

    // Monitor: compares bus activity against the scoreboard queue.
    initial begin
      pend = 1'b0; pscl = 1'b1; psda = 1'b1; rx = '0; nb = 0;
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
          c("rst_scl", int'(scl), 1);
          c("rst_sda", int'(sda), 1);
          c("rst_busy", int'(busy), 0);
          c("rst_gnt", int'({gnt_a, gnt_b}), 0);
          c("rst_done", int'(done), 0);
          pend = 1'b0;
        end else begin
          if (q.size() > 0 && q[0].gcyc == cyc) begin
            pe = q.pop_front();
            c("gnt_a", int'(gnt_a), int'(pe.who == 1));
            c("gnt_b", int'(gnt_b), int'(pe.who == 2));
            pend = 1'b1;
            rx   = '0;
            nb   = 0;
          end else begin
            c("gnt_none", int'({gnt_a, gnt_b}), 0);
          end
          if (pend && !pscl && scl) begin
            if (nb < 4) rx = {rx[2:0], sda};
            nb++;
          end
          if (sda !== psda)
            c("sda_edge", int'(!scl || ((gnt_a || gnt_b) && !sda) || (done && sda)), 1);
          c("done", int'(done), int'(pend && cyc == pe.dcyc));
          if (pend && cyc >= pe.dcyc) begin
            c("code", int'(rx), pe.code);
            c("scl_rises", nb, 5);
            pend = 1'b0;
          end
          c("busy", int'(busy), int'(pend));
          if (!pend) begin
            c("idle_scl", int'(scl), 1);
            c("idle_sda", int'(sda), 1);
          end
        end
        pscl = scl;
        psda = sda;
      end
    end
  end

  // Completion and summary
  initial begin
    for (int i = 0; i < 50000 && !(g_cfg[0].fin && g_cfg[1].fin); i++) @(posedge clk);
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: stimulus finished=0, expected 1");
    end
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
